// File: rtl/sync_memory_pkg.sv
// Shared types and default parameter values for sync_memory and its read pipeline.
package memory_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int unsigned     DEFAULT_DATA_WIDTH   = 8;
  localparam int unsigned     DEFAULT_ADDR_WIDTH   = 12;
  localparam int unsigned     DEFAULT_READ_LATENCY = 1;
  localparam logic [7:0]      DEFAULT_INIT_VALUE   = 8'h88;

endpackage

// File: rtl/sync_memory_if.sv
// Request/response bus of sync_memory; rsp_error exists only with SYNC_MEMORY_PARITY_EN.
interface sync_memory_if #(
  parameter int unsigned DATA_WIDTH = memory_pkg::DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = memory_pkg::DEFAULT_ADDR_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  clear_start;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  busy;
`ifdef SYNC_MEMORY_PARITY_EN
  logic                  rsp_error;
`endif

  modport master (
    output req_valid, req_write, req_addr, req_wdata, clear_start,
    input  req_ready, rsp_valid, rsp_rdata, busy
`ifdef SYNC_MEMORY_PARITY_EN
    , input rsp_error
`endif
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, clear_start,
    output req_ready, rsp_valid, rsp_rdata, busy
`ifdef SYNC_MEMORY_PARITY_EN
    , output rsp_error
`endif
  );

endinterface

// File: rtl/sync_memory_read_pipe.sv
// mem_read_pipe: LATENCY-stage valid/data delay line; each data stage only loads on a valid
// beat, so the last stage holds the previous response until the next one arrives.
module mem_read_pipe #(
  parameter int unsigned LATENCY = memory_pkg::DEFAULT_READ_LATENCY,
  parameter int unsigned WIDTH   = memory_pkg::DEFAULT_DATA_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [LATENCY-1:0] vld;
  logic [WIDTH-1:0]   dat [LATENCY];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        dat[i] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      if (in_valid) begin
        dat[0] <= in_data;
      end
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) begin
          dat[i] <= dat[i-1];
        end
      end
    end
  end

  assign out_valid = vld[LATENCY-1];
  assign out_data  = dat[LATENCY-1];

endmodule

// File: rtl/sync_memory.sv
// sync_memory: word array with a runtime clear sequencer and fixed-latency reads.
// Define SYNC_MEMORY_PARITY_EN to store an even-parity bit per word and report rsp_error.
module sync_memory
  import memory_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int unsigned           ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int unsigned           READ_LATENCY = DEFAULT_READ_LATENCY,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = DATA_WIDTH'(DEFAULT_INIT_VALUE)
) (
  input logic          clock,
  input logic          reset_n,
  sync_memory_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  ready_q;
  logic                  busy_q;
  logic                  accept;
  logic                  rd_accept;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // clear_start wins over a concurrent request, so it masks ready combinationally
  assign bus.req_ready = ready_q & ~bus.clear_start;
  assign bus.busy      = busy_q;
  assign accept        = bus.req_valid & bus.req_ready;
  assign rd_accept     = accept & ~bus.req_write;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b1;
    end else if (state == CLEAR) begin
      if (clr_addr == '1) begin
        state   <= IDLE;
        ready_q <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        clr_addr <= clr_addr + 1'b1;
      end
    end else if (bus.clear_start) begin
      state    <= CLEAR;
      clr_addr <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b1;
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = bus.req_addr;
    wr_data = bus.req_wdata;
    if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = INIT_VALUE;
    end else if (accept && bus.req_write) begin
      wr_en = 1'b1;
    end
  end

  // Array has no reset; the clear sequence that follows reset rewrites it
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_word = mem[bus.req_addr];

`ifdef SYNC_MEMORY_PARITY_EN
  localparam int unsigned PIPE_WIDTH = DATA_WIDTH + 1;

  logic                  par_mem [DEPTH];
  logic                  rd_err;
  logic [PIPE_WIDTH-1:0] pipe_in;
  logic [PIPE_WIDTH-1:0] pipe_out;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      par_mem[wr_addr] <= ^wr_data;
    end
  end

  // Error is judged at acceptance so it travels alongside its data word
  assign rd_err        = (^rd_word) ^ par_mem[bus.req_addr];
  assign pipe_in       = {rd_err, rd_word};
  assign bus.rsp_error = pipe_out[DATA_WIDTH];
`else
  localparam int unsigned PIPE_WIDTH = DATA_WIDTH;

  logic [PIPE_WIDTH-1:0] pipe_in;
  logic [PIPE_WIDTH-1:0] pipe_out;

  assign pipe_in = rd_word;
`endif

  assign bus.rsp_rdata = pipe_out[DATA_WIDTH-1:0];

  mem_read_pipe #(
    .LATENCY (READ_LATENCY),
    .WIDTH   (PIPE_WIDTH)
  ) u_read_pipe (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (rd_accept),
    .in_data   (pipe_in),
    .out_valid (bus.rsp_valid),
    .out_data  (pipe_out)
  );

endmodule

// File: doc/sync_memory.md
SYNC_MEMORY -- requirements
Module: sync_memory

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, address width; depth = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter READ_LATENCY, default 1, legal 1..4, cycles from read acceptance to rsp_valid.
REQ-004 SHALL have parameter INIT_VALUE, default 8'h88 zero-extended or truncated to DATA_WIDTH, word written by clear sequence.
REQ-005 clock  input  1  single clock, all logic on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  request can be accepted this cycle.
REQ-009 req_write  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_WIDTH  word address.
REQ-011 req_wdata  input  DATA_WIDTH  write data.
REQ-012 clear_start  input  1  pulse starting a runtime clear of the whole array.
REQ-013 rsp_valid  output  1  read data valid, single-cycle pulse per read.
REQ-014 rsp_rdata  output  DATA_WIDTH  read data, held until next rsp_valid.
REQ-015 busy  output  1  clear sequence in progress.

Function
REQ-016 Request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-017 FSM states SHALL be CLEAR and IDLE; reset release enters CLEAR.
REQ-018 In CLEAR: one word per cycle written with INIT_VALUE, address 0 upward, req_ready=0, busy=1.
REQ-019 CLEAR SHALL exit to IDLE on the cycle after address DEPTH-1 is written; counter SHALL not wrap.
REQ-020 In IDLE: req_ready=1, busy=0; clear_start=1 SHALL move to CLEAR with counter 0 and ignore any concurrent request (req_ready=0 that cycle).
REQ-021 clear_start during CLEAR SHALL be ignored.
REQ-022 Accepted write SHALL update mem[req_addr] at that edge; writes produce no response.
REQ-023 Accepted read SHALL assert rsp_valid exactly READ_LATENCY cycles later with that word.
REQ-024 Read accepted the cycle after a write to the same address SHALL return the new data.
REQ-025 Back-to-back reads SHALL be accepted every cycle; responses in request order, no backpressure.
REQ-026 Reads in flight on entry to CLEAR SHALL still complete with data read at acceptance.
REQ-027 Data bus SHALL never be tri-stated; read and write paths are separate.

Reset
REQ-028 reset_n low SHALL force state=CLEAR, counter=0, req_ready=0, busy=1, rsp_valid=0, rsp_rdata=0, pipeline valids cleared.
REQ-029 Array contents SHALL not be reset asynchronously; they are rewritten by CLEAR after release.
REQ-030 Reset asserted mid-CLEAR or with reads in flight SHALL discard them; clear restarts from 0.

Configuration
REQ-031 Macro SYNC_MEMORY_PARITY_EN SHALL add output rsp_error (1 bit) and one even-parity bit per word.
REQ-032 With macro: parity stored on write/clear, checked on read, rsp_error valid with rsp_valid, reset 0.
REQ-033 Without macro: no parity storage, no rsp_error port.

Structure
REQ-034 Package memory_pkg SHALL hold the state typedef and default parameter constants.
REQ-035 Sub-module mem_read_pipe SHALL implement the READ_LATENCY valid/data delay line.

Verification (DATA_WIDTH=8, ADDR_WIDTH=12, READ_LATENCY=2)
REQ-036 Release reset -> busy=1 for 4096 cycles, then req_ready=1; reads of 0x000 and 0xFFF return 8'h88.
REQ-037 Write 0x5A to 0x123, read 0x123 next cycle -> rsp_valid two cycles after read, rsp_rdata=0x5A.
REQ-038 Reads of 0x001,0x002,0x003 on consecutive cycles -> three consecutive rsp_valid pulses, in order.
REQ-039 clear_start with req_valid=1 in IDLE -> request not accepted, 4096 clear cycles, then 0x123 reads 8'h88.
REQ-040 reset_n low at clear address 0x800 -> outputs at reset values; after release clear restarts from 0x000.
REQ-041 With SYNC_MEMORY_PARITY_EN, force parity bit flip at 0x010 -> read gives rsp_error=1 with rsp_valid.
